// File: rtl/game_state_scorer.sv
// Game-state tracker: counts rising edges of the winner/loser flags,
// declares game over at either target and holds the result until restart.
module game_state_scorer #(
    parameter int SCORE_W     = 4,
    parameter int WIN_TARGET  = 15,
    parameter int LOSE_TARGET = 15,
    parameter bit TIE_WHO     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               winner_flag,
    input  logic               loser_flag,
    input  logic               restart,
    output logic               gameover,
    output logic               gameover_pulse,
    output logic               who,
    output logic [SCORE_W-1:0] win_score,
    output logic [SCORE_W-1:0] lose_score
);

    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    generate
        if (WIN_TARGET < 1 || WIN_TARGET > SCORE_MAX) begin : g_bad_win
            $error("WIN_TARGET out of range for SCORE_W");
        end
        if (LOSE_TARGET < 1 || LOSE_TARGET > SCORE_MAX) begin : g_bad_lose
            $error("LOSE_TARGET out of range for SCORE_W");
        end
    endgenerate

    localparam logic [SCORE_W-1:0] WIN_T  = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] LOSE_T = SCORE_W'(LOSE_TARGET);

    typedef enum logic {PLAY, OVER} state_t;

    state_t             state;
    state_t             state_nx;
    logic               win_q;
    logic               lose_q;
    logic               win_ev;
    logic               lose_ev;
    logic               win_hit;
    logic               lose_hit;
    logic               pulse_q;
    logic               who_q;
    logic [SCORE_W-1:0] win_nx;
    logic [SCORE_W-1:0] lose_nx;

    assign win_ev  = winner_flag & ~win_q;
    assign lose_ev = loser_flag & ~lose_q;

    // Scores stay below their targets in PLAY, so the increment cannot wrap.
    always_comb begin
        win_nx   = win_score + SCORE_W'(win_ev);
        lose_nx  = lose_score + SCORE_W'(lose_ev);
        win_hit  = win_ev & (win_nx == WIN_T);
        lose_hit = lose_ev & (lose_nx == LOSE_T);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PLAY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = PLAY;
        end else if (state == PLAY && (win_hit || lose_hit)) begin
            state_nx = OVER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            win_score  <= '0;
            lose_score <= '0;
            pulse_q    <= 1'b0;
            who_q      <= 1'b0;
        end else begin
            win_q  <= winner_flag;
            lose_q <= loser_flag;
            if (restart) begin
                win_score  <= '0;
                lose_score <= '0;
                pulse_q    <= 1'b0;
                who_q      <= 1'b0;
            end else if (state == PLAY) begin
                win_score  <= win_nx;
                lose_score <= lose_nx;
                pulse_q    <= win_hit | lose_hit;
                if (win_hit || lose_hit) begin
                    who_q <= (win_hit && lose_hit) ? TIE_WHO : win_hit;
                end
            end else begin
                pulse_q <= 1'b0;
            end
        end
    end

    always_comb begin
        gameover       = (state == OVER);
        gameover_pulse = pulse_q;
        who            = who_q;
    end

endmodule

// File: tb/tb_game_state_scorer.sv
// Bench for game_state_scorer: three parameter sets share one stimulus
// stream and are checked every cycle against a rule-level model.
module tb_game_state_scorer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic winner_flag = 1'b0;
    logic loser_flag = 1'b0;
    logic restart = 1'b0;

    logic       go[3];
    logic       gp[3];
    logic       wh[3];
    logic [3:0] wsc[3];
    logic [3:0] lsc[3];

    int n_chk = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Per-instance targets and tie value, matching the instances below.
    int wt[3] = '{15, 3, 5};
    int lt[3] = '{15, 3, 2};
    bit tw[3] = '{1'b1, 1'b0, 1'b1};

    int m_ws[3];
    int m_ls[3];
    bit m_over[3];
    bit m_who[3];
    bit m_pls[3];
    bit m_wq;
    bit m_lq;

    always #5 clk = ~clk;

    game_state_scorer #(
        .SCORE_W(4), .WIN_TARGET(15), .LOSE_TARGET(15), .TIE_WHO(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .winner_flag(winner_flag),
        .loser_flag(loser_flag), .restart(restart), .gameover(go[0]),
        .gameover_pulse(gp[0]), .who(wh[0]), .win_score(wsc[0]),
        .lose_score(lsc[0])
    );

    game_state_scorer #(
        .SCORE_W(4), .WIN_TARGET(3), .LOSE_TARGET(3), .TIE_WHO(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .winner_flag(winner_flag),
        .loser_flag(loser_flag), .restart(restart), .gameover(go[1]),
        .gameover_pulse(gp[1]), .who(wh[1]), .win_score(wsc[1]),
        .lose_score(lsc[1])
    );

    game_state_scorer #(
        .SCORE_W(4), .WIN_TARGET(5), .LOSE_TARGET(2), .TIE_WHO(1'b1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .winner_flag(winner_flag),
        .loser_flag(loser_flag), .restart(restart), .gameover(go[2]),
        .gameover_pulse(gp[2]), .who(wh[2]), .win_score(wsc[2]),
        .lose_score(lsc[2])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task model_clear();
        for (int i = 0; i < 3; i++) begin
            m_ws[i] = 0;
            m_ls[i] = 0;
            m_over[i] = 1'b0;
            m_who[i] = 1'b0;
            m_pls[i] = 1'b0;
        end
        m_wq = 1'b0;
        m_lq = 1'b0;
    endtask

    // One clock of the game rules, applied to each parameter set.
    task model_step();
        bit we;
        bit le;
        bit hw;
        bit hl;
        we = winner_flag && !m_wq;
        le = loser_flag && !m_lq;
        for (int i = 0; i < 3; i++) begin
            if (restart) begin
                m_ws[i] = 0;
                m_ls[i] = 0;
                m_over[i] = 1'b0;
                m_who[i] = 1'b0;
                m_pls[i] = 1'b0;
            end else if (m_over[i]) begin
                m_pls[i] = 1'b0;
            end else begin
                m_ws[i] += int'(we);
                m_ls[i] += int'(le);
                hw = we && (m_ws[i] == wt[i]);
                hl = le && (m_ls[i] == lt[i]);
                m_pls[i] = hw || hl;
                if (hw || hl) begin
                    m_over[i] = 1'b1;
                    m_who[i] = (hw && hl) ? tw[i] : hw;
                end
            end
        end
        m_wq = winner_flag;
        m_lq = loser_flag;
    endtask

    initial model_clear();

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) model_step();
        else model_clear();
        #1;
        if (checking && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("m%0d gameover", i), 32'(go[i]), 32'(m_over[i]));
                chk($sformatf("m%0d pulse", i), 32'(gp[i]), 32'(m_pls[i]));
                chk($sformatf("m%0d who", i), 32'(wh[i]), 32'(m_who[i]));
                chk($sformatf("m%0d win", i), 32'(wsc[i]), 32'(m_ws[i]));
                chk($sformatf("m%0d lose", i), 32'(lsc[i]), 32'(m_ls[i]));
            end
        end
    end

    task automatic pulse_w(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) winner_flag = 1'b1;
            @(negedge clk) winner_flag = 1'b0;
        end
    endtask

    task automatic pulse_l(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) loser_flag = 1'b1;
            @(negedge clk) loser_flag = 1'b0;
        end
    endtask

    task automatic do_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst gameover", 32'(go[0]), 0);
        chk("rst win", 32'(wsc[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;

        // 15 separate winner pulses on the default instance
        pulse_w(14);
        chk("t1 win14", 32'(wsc[0]), 14);
        chk("t1 go14", 32'(go[0]), 0);
        pulse_w(1);
        chk("t1 win15", 32'(wsc[0]), 15);
        chk("t1 go", 32'(go[0]), 1);
        chk("t1 who", 32'(wh[0]), 1);
        chk("t1 pulse", 32'(gp[0]), 1);
        @(negedge clk);
        chk("t1 pulse off", 32'(gp[0]), 0);
        chk("t1 go held", 32'(go[0]), 1);
        do_restart();

        // held flag counts once
        @(negedge clk) winner_flag = 1'b1;
        repeat (10) @(negedge clk);
        chk("t2 held", 32'(wsc[0]), 1);
        winner_flag = 1'b0;
        @(negedge clk) winner_flag = 1'b1;
        @(negedge clk);
        chk("t2 rerise", 32'(wsc[0]), 2);
        winner_flag = 1'b0;
        do_restart();

        // tie on instance B, lose-target win on instance C
        pulse_w(2);
        pulse_l(2);
        chk("t4 c go", 32'(go[2]), 1);
        chk("t4 c who", 32'(wh[2]), 0);
        chk("t4 c pulse", 32'(gp[2]), 1);
        @(negedge clk) begin
            winner_flag = 1'b1;
            loser_flag = 1'b1;
        end
        @(negedge clk) begin
            winner_flag = 1'b0;
            loser_flag = 1'b0;
        end
        chk("t3 b win", 32'(wsc[1]), 3);
        chk("t3 b lose", 32'(lsc[1]), 3);
        chk("t3 b go", 32'(go[1]), 1);
        chk("t3 b who", 32'(wh[1]), 0);
        chk("t3 b pulse", 32'(gp[1]), 1);
        pulse_w(2);
        pulse_l(2);
        chk("t4 c win", 32'(wsc[2]), 2);
        chk("t4 c lose", 32'(lsc[2]), 2);
        chk("t4 c who held", 32'(wh[2]), 0);
        chk("t4 c no pulse", 32'(gp[2]), 0);
        chk("t4 b frozen", 32'(wsc[1]), 3);

        // restart coincident with a rise, flag held
        @(negedge clk) begin
            restart = 1'b1;
            winner_flag = 1'b1;
        end
        @(negedge clk) restart = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 win", 32'(wsc[0]), 0);
        chk("t5 go", 32'(go[1]), 0);
        winner_flag = 1'b0;
        @(negedge clk) winner_flag = 1'b1;
        @(negedge clk);
        chk("t5 rerise", 32'(wsc[0]), 1);
        winner_flag = 1'b0;
        do_restart();

        // asynchronous reset between edges
        pulse_w(7);
        chk("t6 win7", 32'(wsc[0]), 7);
        chk("t6 c go", 32'(go[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 win", 32'(wsc[0]), 0);
        chk("t6 c go", 32'(go[2]), 0);
        chk("t6 c pulse", 32'(gp[2]), 0);
        chk("t6 c who", 32'(wh[2]), 0);
        winner_flag = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t6 flag at release", 32'(wsc[0]), 1);
        winner_flag = 1'b0;

        // random play
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) winner_flag = ~winner_flag;
            if ($urandom_range(0, 2) == 0) loser_flag = ~loser_flag;
            restart = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk) restart = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
